frac_bin_to_dec_seq: RTL and testbench

Sequential controller that converts a W-bit unsigned binary fraction (0.b1b2..bW) into its exact decimal digit string, most-significant digit first.
- Emits one digit per cycle over a valid/ready stream.
- Method: repeated multiply-by-10 of the fractional remainder.
- This is the synthesizable counterpart of the team's simulation-only fraction-to-real conversion. It feeds display/UART formatting logic downstream.

---
 rtl/frac_conv_pkg.sv | 32 +++
 rtl/frac_mul10_digit.sv | 29 ++
 rtl/frac_bin_to_dec_seq.sv | 113 +++++++++++
 tb/tb_frac_bin_to_dec_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/frac_conv_pkg.sv
// Shared types and the multiply-by-10 digit step for the binary-fraction
// to decimal-string converter.
package frac_conv_pkg;

  // Converter control states: waiting for a fraction, or streaming digits.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // A BCD digit is four bits wide.
  localparam int DIGIT_W = 4;

  // The digit step always works on a 32-bit, MSB-aligned fraction so that a
  // single package function serves every legal fraction width.  The caller
  // left-justifies its W-bit remainder and takes the top W bits of the
  // returned remainder; the low 32-W bits stay zero throughout.
  localparam int STEP_W = 32;

  // Multiply an MSB-aligned fraction by ten and return {digit, remainder}.
  // The integer part of rem*10 is the next decimal digit, and the fractional
  // part is what remains to be converted.  Because rem < 1, rem*10 < 10, so
  // the digit field never exceeds 9.
  function automatic logic [DIGIT_W+STEP_W-1:0] mul10_step(
    input logic [STEP_W-1:0] rem
  );
    logic [DIGIT_W+STEP_W-1:0] wide;
    wide = {{DIGIT_W{1'b0}}, rem};
    return (wide << 3) + (wide << 1);
  endfunction

endpackage

// File: rtl/frac_mul10_digit.sv
// Combinational digit step: multiplies a W-bit binary fraction by ten and
// splits the product into the next decimal digit and the new remainder.
module frac_mul10_digit
  import frac_conv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]       rem,
  output logic [DIGIT_W-1:0] digit,
  output logic [W-1:0]       rem_n
);

  logic [STEP_W-1:0]         aligned;
  logic [DIGIT_W+STEP_W-1:0] product;
  logic                      unused_low_bits;

  // Left-justify so bit W-1 of the fraction lands on the 2^-1 position of
  // the 32-bit step; this keeps the digit in the same place for every W.
  assign aligned = STEP_W'(rem) << (STEP_W - W);
  assign product = mul10_step(aligned);

  assign digit = product[DIGIT_W+STEP_W-1:STEP_W];
  assign rem_n = product[STEP_W-1 -: W];

  // The bits below the W-bit window are structurally zero; fold them into a
  // sink so they do not show up as dangling logic.
  assign unused_low_bits = ^product;

endmodule

// File: rtl/frac_bin_to_dec_seq.sv
// Sequential converter from a W-bit unsigned binary fraction 0.b1..bW to its
// decimal digit string, most-significant digit first, one digit per cycle
// over a valid/ready stream.  Conversion stops at the first zero remainder
// or after MAX_DIG digits, flagging a truncated non-zero tail as inexact.
module frac_bin_to_dec_seq
  import frac_conv_pkg::*;
#(
  parameter  int W       = 8,
  parameter  int MAX_DIG = W,
  localparam int CW      = $clog2(MAX_DIG + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       frac_in,
  input  logic               abort,
  output logic               dig_valid,
  input  logic               dig_ready,
  output logic [DIGIT_W-1:0] digit,
  output logic [CW-1:0]      dig_idx,
  output logic               dig_last,
  output logic               inexact,
  output logic               busy
);

  state_t               state;
  logic [W-1:0]         rem;

  logic [W-1:0]         step_src;
  logic [DIGIT_W-1:0]   step_digit;
  logic [W-1:0]         step_rem;
  logic [CW-1:0]        next_idx;
  logic                 next_last;
  logic                 accept;

  // Acceptance is only possible from IDLE, never while abort is raised, and
  // never while the block is held in reset.
  assign in_ready  = rst_n && (state == IDLE) && !abort;
  assign accept    = in_valid && in_ready;

  // The stream is valid for exactly as long as a conversion is in flight.
  assign dig_valid = (state == EMIT);
  assign busy      = (state == EMIT);

  // One shared digit-step datapath: it works on the incoming fraction while
  // idle and on the held remainder while emitting.
  assign step_src  = (state == IDLE) ? frac_in : rem;

  frac_mul10_digit #(
    .W (W)
  ) u_step (
    .rem   (step_src),
    .digit (step_digit),
    .rem_n (step_rem)
  );

  // Position and end-of-string decision for the digit the step produces.
  // dig_idx is always below MAX_DIG while a non-final digit is shown, so the
  // increment cannot overflow CW bits.
  always_comb begin
    next_idx  = (state == IDLE) ? CW'(1) : dig_idx + CW'(1);
    next_last = (step_rem == '0) || (next_idx == CW'(MAX_DIG));
  end

  // Control FSM and the registered digit stream.  A digit is replaced only
  // when it is handshaken, so every output stays frozen under backpressure.
  // Returning to IDLE (last digit taken, or abort) clears the stream
  // registers so a stale digit never lingers on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      digit    <= '0;
      dig_idx  <= '0;
      dig_last <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= EMIT;
            rem      <= step_rem;
            digit    <= step_digit;
            dig_idx  <= next_idx;
            dig_last <= next_last;
            inexact  <= next_last && (step_rem != '0);
          end
        end
        EMIT: begin
          if (abort || (dig_ready && dig_last)) begin
            state    <= IDLE;
            rem      <= '0;
            digit    <= '0;
            dig_idx  <= '0;
            dig_last <= 1'b0;
            inexact  <= 1'b0;
          end else if (dig_ready) begin
            rem      <= step_rem;
            digit    <= step_digit;
            dig_idx  <= next_idx;
            dig_last <= next_last;
            inexact  <= next_last && (step_rem != '0);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frac_bin_to_dec_seq.sv
// Self-checking bench for frac_bin_to_dec_seq: directed cases plus randomized
// conversions with random backpressure and aborts, checked against an exact
// arithmetic reference of the decimal expansion.
module tb_frac_bin_to_dec_seq;

  localparam int W       = 8;
  localparam int MAX_DIG = 6;
  localparam int CW      = $clog2(MAX_DIG + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  frac_in = '0;
  logic          abort = 1'b0;
  logic          dig_valid;
  logic          dig_ready = 1'b0;
  logic [3:0]    digit;
  logic [CW-1:0] dig_idx;
  logic          dig_last;
  logic          inexact;
  logic          busy;

  int errors = 0;
  int checks = 0;

  frac_bin_to_dec_seq #(
    .W       (W),
    .MAX_DIG (MAX_DIG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .frac_in   (frac_in),
    .abort     (abort),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digit     (digit),
    .dig_idx   (dig_idx),
    .dig_last  (dig_last),
    .inexact   (inexact),
    .busy      (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count a comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: the k-th decimal digit of frac/2^W is floor(frac*10^k/2^W)
  // mod 10, and the expansion terminates exactly when frac*10^k is a
  // multiple of 2^W.
  task automatic refDigit(input int frac, input int k, output int d,
                          output bit last, output bit inx);
    longint num;
    longint scale;
    bit     exact;
    num   = longint'(frac);
    scale = longint'(1) << W;
    for (int i = 0; i < k; i++) num = num * 10;
    d     = int'((num / scale) % 10);
    exact = ((num % scale) == 0);
    last  = exact || (k == MAX_DIG);
    inx   = last && !exact;
  endtask

  // Run one full conversion of frac.  ready_pct sets the chance that
  // dig_ready is high each cycle; abort_at > 0 raises abort together with
  // dig_ready while that digit is presented.
  task automatic applyStimulus(input logic [W-1:0] frac, input int ready_pct,
                               input int abort_at);
    int  n;
    int  k;
    int  d;
    bit  last;
    bit  inx;
    bit  done;
    bit  aborted;
    int  cycles;

    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    frac_in  = frac;
    @(negedge clk);
    in_valid = 1'b0;
    frac_in  = W'($urandom);
    checkOutput("busy_after_accept", busy, 1);

    k = 1;
    done = 1'b0;
    aborted = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      cycles++;
      refDigit(int'(frac), k, d, last, inx);
      checkOutput($sformatf("dig_valid_%0d", k), dig_valid, 1);
      if (!dig_valid) begin
        done = 1'b1;
      end else begin
        checkOutput($sformatf("digit_%0d", k), digit, d);
        checkOutput($sformatf("dig_idx_%0d", k), dig_idx, k);
        checkOutput($sformatf("dig_last_%0d", k), dig_last, last);
        checkOutput($sformatf("inexact_%0d", k), inexact, inx);
        checkOutput($sformatf("in_ready_busy_%0d", k), in_ready, 0);
        if (abort_at == k) begin
          abort     = 1'b1;
          dig_ready = 1'b1;
          @(negedge clk);
          abort     = 1'b0;
          dig_ready = 1'b0;
          aborted   = 1'b1;
          done      = 1'b1;
        end else begin
          dig_ready = ($urandom_range(99) < ready_pct);
          @(negedge clk);
          if (dig_ready) begin
            if (last) done = 1'b1;
            else k++;
          end
        end
      end
    end
    if (cycles >= 200) checkOutput("digit_stream_timeout", 0, 1);
    dig_ready = 1'b0;
    #1;
    checkOutput(aborted ? "dig_valid_after_abort" : "dig_valid_after_last",
                dig_valid, 0);
    checkOutput(aborted ? "in_ready_after_abort" : "in_ready_after_last",
                in_ready, 1);
  endtask

  // Main sequence: reset, directed cases, abort/reset corner cases, then a
  // randomized sweep.
  initial begin
    int frac;
    int pct;
    int ab;

    #12;
    checkOutput("rst_dig_valid", dig_valid, 0);
    checkOutput("rst_digit", digit, 0);
    checkOutput("rst_dig_idx", dig_idx, 0);
    checkOutput("rst_dig_last", dig_last, 0);
    checkOutput("rst_inexact", inexact, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed conversions");
    applyStimulus(8'h28, 100, 0);
    applyStimulus(8'hFF, 100, 0);
    applyStimulus(8'h80, 100, 0);
    applyStimulus(8'h00, 100, 0);
    applyStimulus(8'h01, 100, 0);
    applyStimulus(8'h28, 40, 0);

    $display("[TB] abort while emitting");
    applyStimulus(8'hFF, 100, 2);
    applyStimulus(8'h40, 100, 0);

    $display("[TB] abort while idle");
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    frac_in  = 8'h80;
    #1;
    checkOutput("in_ready_idle_abort", in_ready, 0);
    @(negedge clk);
    checkOutput("busy_idle_abort", busy, 0);
    checkOutput("dig_valid_idle_abort", dig_valid, 0);
    abort    = 1'b0;
    in_valid = 1'b0;

    $display("[TB] reset mid-stream");
    @(negedge clk);
    in_valid  = 1'b1;
    frac_in   = 8'hFF;
    @(negedge clk);
    in_valid  = 1'b0;
    dig_ready = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_dig_valid", dig_valid, 0);
    checkOutput("midrst_digit", digit, 0);
    checkOutput("midrst_dig_idx", dig_idx, 0);
    checkOutput("midrst_dig_last", dig_last, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    dig_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postrst_in_ready", in_ready, 1);
    applyStimulus(8'h40, 100, 0);

    $display("[TB] randomized conversions");
    for (int i = 0; i < 40; i++) begin
      frac = int'($urandom_range(255));
      pct  = ($urandom_range(1) == 0) ? 100 : 50;
      ab   = ($urandom_range(4) == 0) ? int'($urandom_range(3, 1)) : 0;
      applyStimulus(W'(frac), pct, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
